// File: rtl/bdi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bdi_pkg
// Brief    : Encoding codes and packed-size helper for the BDI compressor.
// Revision : 1.0
// ============================================================================
package bdi_pkg;

    localparam int ENC_W = 4;

    typedef enum logic [ENC_W-1:0] {
        ENC_ZERO = 4'd0,
        ENC_REP8 = 4'd1,
        ENC_B8D1 = 4'd2,
        ENC_B8D2 = 4'd3,
        ENC_B8D4 = 4'd4,
        ENC_B4D1 = 4'd5,
        ENC_B4D2 = 4'd6,
        ENC_B2D1 = 4'd7,
        ENC_RAW  = 4'd15
    } enc_e;

    // Packed size in bytes of a line of line_w bits under encoding enc.
    function automatic int bdi_size(input enc_e enc, input int line_w);
        int n8;
        int n4;
        int n2;
        int sz;
        n8 = line_w / 64;
        n4 = line_w / 32;
        n2 = line_w / 16;
        case (enc)
            ENC_ZERO: sz = 0;
            ENC_REP8: sz = 8;
            ENC_B8D1: sz = 8 + (n8 - 1) * 1;
            ENC_B8D2: sz = 8 + (n8 - 1) * 2;
            ENC_B8D4: sz = 8 + (n8 - 1) * 4;
            ENC_B4D1: sz = 4 + (n4 - 1) * 1;
            ENC_B4D2: sz = 4 + (n4 - 1) * 2;
            ENC_B2D1: sz = 2 + (n2 - 1) * 1;
            default:  sz = line_w / 8;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bdi_fit_check.sv
`default_nettype none
// ============================================================================
// Module   : bdi_fit_check
// Brief    : Deltas against word 0 and 1/2/4-byte fit flags for one base size.
// Revision : 1.0
// ============================================================================
module bdi_fit_check #(
    parameter int BASE_B = 8,
    parameter int LINE_W = 256
) (
    input  logic [LINE_W-1:0] i_line,
    output logic [LINE_W-1:0] o_deltas,
    output logic              o_fit1,
    output logic              o_fit2,
    output logic              o_fit4
);

    localparam int c_WORD_W = 8 * BASE_B;
    localparam int c_N      = LINE_W / c_WORD_W;

    logic [c_WORD_W-1:0] w_base;
    logic [c_N-1:0]      w_fit1;
    logic [c_N-1:0]      w_fit2;
    logic [c_N-1:0]      w_fit4;

    // A delta fits D bytes when everything from bit 8D-1 upward is sign copies.
    function automatic logic fits(input logic [c_WORD_W-1:0] d, input int dbytes);
        logic signed [c_WORD_W-1:0] s;
        if (dbytes >= BASE_B) begin
            return 1'b1;
        end
        s = $signed(d) >>> (8 * dbytes - 1);
        return (&s) | ~(|s);
    endfunction

    assign w_base                     = i_line[c_WORD_W-1:0];
    assign o_deltas[c_WORD_W-1:0]     = w_base;
    assign w_fit1[0]                  = 1'b1;
    assign w_fit2[0]                  = 1'b1;
    assign w_fit4[0]                  = 1'b1;

    generate
        for (genvar i = 1; i < c_N; i++) begin : g_word
            logic [c_WORD_W-1:0] w_delta;
            assign w_delta                         = i_line[i*c_WORD_W +: c_WORD_W] - w_base;
            assign o_deltas[i*c_WORD_W +: c_WORD_W] = w_delta;
            assign w_fit1[i]                       = fits(w_delta, 1);
            assign w_fit2[i]                       = fits(w_delta, 2);
            assign w_fit4[i]                       = fits(w_delta, 4);
        end
    endgenerate

    assign o_fit1 = &w_fit1;
    assign o_fit2 = &w_fit2;
    assign o_fit4 = &w_fit4;

endmodule
`default_nettype wire

// File: rtl/bdi_compressor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bdi_compressor_pipe
// Brief    : Two-stage base-delta-immediate line compressor with backpressure.
//            Optional statistics counters enabled by macro BDI_STATS_EN.
// Revision : 1.0
// ============================================================================
module bdi_compressor_pipe
    import bdi_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LINE_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LINE_W-1:0]         out_data,
    output logic [ENC_W-1:0]          out_enc,
    output logic [$clog2(LINE_W/8):0] out_len
`ifdef BDI_STATS_EN
    ,
    output logic [CNT_W-1:0]          stat_lines,
    output logic [CNT_W-1:0]          stat_raw,
    output logic [CNT_W-1:0]          stat_saved
`endif
);

    localparam int c_LINE_B = LINE_W / 8;
    localparam int c_LEN_W  = $clog2(c_LINE_B) + 1;
    localparam int c_N64    = LINE_W / 64;

    // ------------------------------------------------------------------
    // Stage 0: per-mode legality and deltas
    // ------------------------------------------------------------------
    logic              w_zero;
    logic              w_rep;
    logic [LINE_W-1:0] w_d8;
    logic [LINE_W-1:0] w_d4;
    logic [LINE_W-1:0] w_d2;
    logic              w_f8_1, w_f8_2, w_f8_4;
    logic              w_f4_1, w_f4_2, w_f4_4;
    logic              w_f2_1, w_f2_2, w_f2_4;
    logic [7:0]        w_fit;
    logic              w_unused_fit;

    assign w_zero = ~|in_data;

    always_comb begin
        w_rep = 1'b1;
        for (int i = 1; i < c_N64; i++) begin
            if (in_data[i*64 +: 64] != in_data[63:0]) begin
                w_rep = 1'b0;
            end
        end
    end

    bdi_fit_check #(.BASE_B(8), .LINE_W(LINE_W)) u_fit8 (
        .i_line   (in_data),
        .o_deltas (w_d8),
        .o_fit1   (w_f8_1),
        .o_fit2   (w_f8_2),
        .o_fit4   (w_f8_4)
    );

    bdi_fit_check #(.BASE_B(4), .LINE_W(LINE_W)) u_fit4 (
        .i_line   (in_data),
        .o_deltas (w_d4),
        .o_fit1   (w_f4_1),
        .o_fit2   (w_f4_2),
        .o_fit4   (w_f4_4)
    );

    bdi_fit_check #(.BASE_B(2), .LINE_W(LINE_W)) u_fit2 (
        .i_line   (in_data),
        .o_deltas (w_d2),
        .o_fit1   (w_f2_1),
        .o_fit2   (w_f2_2),
        .o_fit4   (w_f2_4)
    );

    // Bit m of w_fit is the legality of encoding m.
    assign w_fit        = {w_f2_1, w_f4_2, w_f4_1, w_f8_4, w_f8_2, w_f8_1, w_rep, w_zero};
    assign w_unused_fit = ^{w_f4_4, w_f2_2, w_f2_4};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv & ~rst;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [LINE_W-1:0] r_s1_line;
    logic [LINE_W-1:0] r_s1_d8;
    logic [LINE_W-1:0] r_s1_d4;
    logic [LINE_W-1:0] r_s1_d2;
    logic [7:0]        r_s1_fit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_line <= in_data;
                r_s1_d8   <= w_d8;
                r_s1_d4   <= w_d4;
                r_s1_d2   <= w_d2;
                r_s1_fit  <= w_fit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Selection and packing
    // ------------------------------------------------------------------
    enc_e              w_sel_enc;
    logic [c_LEN_W-1:0] w_sel_len;
    logic [LINE_W-1:0] w_sel_data;

    // Base in the low b bytes, then the low dd bytes of each delta, ascending.
    function automatic logic [LINE_W-1:0] pack_bd(input logic [LINE_W-1:0] d,
                                                  input int b, input int dd);
        logic [LINE_W-1:0] p;
        p = '0;
        for (int k = 0; k < b; k++) begin
            p[k*8 +: 8] = d[k*8 +: 8];
        end
        for (int i = 1; i < LINE_W / (8 * b); i++) begin
            for (int k = 0; k < dd; k++) begin
                p[(b + (i - 1) * dd + k) * 8 +: 8] = d[(i * b + k) * 8 +: 8];
            end
        end
        return p;
    endfunction

    // Strict less-than keeps ties on the lower code and only leaves RAW for a real saving.
    always_comb begin
        int v_best;
        v_best    = c_LINE_B;
        w_sel_enc = ENC_RAW;
        for (int m = 0; m < 8; m++) begin
            if (r_s1_fit[m] && (bdi_size(enc_e'(ENC_W'(m)), LINE_W) < v_best)) begin
                v_best    = bdi_size(enc_e'(ENC_W'(m)), LINE_W);
                w_sel_enc = enc_e'(ENC_W'(m));
            end
        end
        w_sel_len = c_LEN_W'(v_best);
    end

    always_comb begin
        w_sel_data = '0;
        case (w_sel_enc)
            ENC_ZERO: w_sel_data = '0;
            ENC_REP8: w_sel_data[63:0] = r_s1_line[63:0];
            ENC_B8D1: w_sel_data = pack_bd(r_s1_d8, 8, 1);
            ENC_B8D2: w_sel_data = pack_bd(r_s1_d8, 8, 2);
            ENC_B8D4: w_sel_data = pack_bd(r_s1_d8, 8, 4);
            ENC_B4D1: w_sel_data = pack_bd(r_s1_d4, 4, 1);
            ENC_B4D2: w_sel_data = pack_bd(r_s1_d4, 4, 2);
            ENC_B2D1: w_sel_data = pack_bd(r_s1_d2, 2, 1);
            default:  w_sel_data = r_s1_line;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [LINE_W-1:0]  r_out_data;
    enc_e               r_out_enc;
    logic [c_LEN_W-1:0] r_out_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_enc   <= ENC_ZERO;
            r_out_len   <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sel_data;
                r_out_enc  <= w_sel_enc;
                r_out_len  <= w_sel_len;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_enc   = r_out_enc;
    assign out_len   = r_out_len;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BDI_STATS_EN
    logic [CNT_W-1:0]   r_stat_lines;
    logic [CNT_W-1:0]   r_stat_raw;
    logic [CNT_W-1:0]   r_stat_saved;
    logic [c_LEN_W-1:0] w_saved_inc;
    logic [CNT_W:0]     w_saved_sum;
    logic               w_out_xfer;

    assign w_out_xfer  = r_out_valid & out_ready;
    assign w_saved_inc = c_LEN_W'(c_LINE_B) - r_out_len;
    assign w_saved_sum = {1'b0, r_stat_saved} + (CNT_W+1)'(w_saved_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_lines <= '0;
            r_stat_raw   <= '0;
            r_stat_saved <= '0;
        end else if (w_out_xfer) begin
            if (~&r_stat_lines) begin
                r_stat_lines <= r_stat_lines + 1'b1;
            end
            if ((r_out_enc == ENC_RAW) && ~&r_stat_raw) begin
                r_stat_raw <= r_stat_raw + 1'b1;
            end
            r_stat_saved <= w_saved_sum[CNT_W] ? '1 : w_saved_sum[CNT_W-1:0];
        end
    end

    assign stat_lines = r_stat_lines;
    assign stat_raw   = r_stat_raw;
    assign stat_saved = r_stat_saved;
`else
    localparam int c_UNUSED_CNT_W = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bdi_compressor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bdi_compressor_pipe
// Brief    : Scoreboard bench for bdi_compressor_pipe with directed vectors.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bdi_compressor_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_data;
    logic [3:0]   out_enc;
    logic [5:0]   out_len;
`ifdef BDI_STATS_EN
    logic [31:0]  stat_lines;
    logic [31:0]  stat_raw;
    logic [31:0]  stat_saved;
`endif

    always #5 clk = ~clk;

    bdi_compressor_pipe #(.LINE_W(256), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_enc   (out_enc),
        .out_len   (out_len)
`ifdef BDI_STATS_EN
        ,
        .stat_lines(stat_lines),
        .stat_raw  (stat_raw),
        .stat_saved(stat_saved)
`endif
    );

    typedef struct {
        logic [255:0] data;
        logic [3:0]   enc;
        logic [5:0]   len;
        int           stamp;
    } exp_t;

    exp_t         sb[$];
    exp_t         pend;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           accepted = 0;
    bit           check_lat = 1'b1;
    bit           held_v = 1'b0;
    logic [255:0] held_d;
    logic [3:0]   held_e;
    logic [5:0]   held_l;

    logic [255:0] vec   [9];
    logic [255:0] exp_d [9];
    logic [3:0]   exp_e [9];
    logic [5:0]   exp_l [9];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Input side pushes expectations; output side pops and compares.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e = pend;
                e.stamp = cyc;
                sb.push_back(e);
                accepted++;
            end
            if (out_valid && held_v) begin
                chk("stall_data", out_data, held_d);
                chk("stall_enc", out_enc, held_e);
                chk("stall_len", out_len, held_l);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_e = out_enc;
            held_l = out_len;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_enc", out_enc, e.enc);
                    chk("out_len", out_len, e.len);
                    if (check_lat) chk("latency", cyc - e.stamp, 256'd2);
                end
            end
        end
    end

    task automatic send(input int idx);
        int waited;
        waited = 0;
        in_valid  = 1'b1;
        in_data   = vec[idx];
        pend.data = exp_d[idx];
        pend.enc  = exp_e[idx];
        pend.len  = exp_l[idx];
        pend.stamp = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("send_timeout", 256'd1, 256'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 256'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0] = '0;
        exp_d[0] = '0; exp_e[0] = 4'd0; exp_l[0] = 6'd0;
        vec[1] = {4{64'h1122334455667788}};
        exp_d[1] = 256'h1122334455667788; exp_e[1] = 4'd1; exp_l[1] = 6'd8;
        vec[2] = {64'h1010, 64'h0FFE, 64'h1005, 64'h1000};
        exp_d[2] = 256'h10FE05_0000000000001000; exp_e[2] = 4'd2; exp_l[2] = 6'd11;
        vec[3] = {64'hDEADBEEFCAFEBABE, 64'h0123456789ABCDEF, 64'hF0E1D2C3B4A59687, 64'h8877665544332211};
        exp_d[3] = vec[3]; exp_e[3] = 4'd15; exp_l[3] = 6'd32;
        vec[4] = {64'h100000, 64'h0FFF00, 64'h100100, 64'h100000};
        exp_d[4] = 256'h0000_FF00_0100_0000000000100000; exp_e[4] = 4'd3; exp_l[4] = 6'd14;
        vec[5] = {64'h100000000, 64'h080000000, 64'h17FFFFFFF, 64'h100000000};
        exp_d[5] = 256'h00000000_80000000_7FFFFFFF_0000000100000000; exp_e[5] = 4'd4; exp_l[5] = 6'd20;
        vec[6] = 256'h3FFFFFFE_40000004_40000003_40000000_40000002_3FFFFFFF_40000001_40000000;
        exp_d[6] = 256'hFE04030002FF0140000000; exp_e[6] = 4'd5; exp_l[6] = 6'd11;
        vec[7] = 256'h1243_1242_1241_1240_123F_123E_123D_123C_123B_123A_1239_1238_1237_1236_1235_1234;
        exp_d[7] = 256'h0F0E0D0C0B0A090807060504030201_1234; exp_e[7] = 4'd7; exp_l[7] = 6'd17;
        vec[8] = {64'h5, 64'h5, 64'h6, 64'h5};
        exp_d[8] = 256'h000001_0000000000000005; exp_e[8] = 4'd2; exp_l[8] = 6'd11;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 256'd0);
        chk("rst_out_data", out_data, 256'd0);
        chk("rst_out_enc", out_enc, 256'd0);
        chk("rst_out_len", out_len, 256'd0);
        chk("rst_in_ready", in_ready, 256'd0);
        rst = 1'b0;

        // Back-to-back stream, every result two cycles after its transfer
        check_lat = 1'b1;
        for (int i = 0; i < 9; i++) send(i);
        drain();

        // Backpressure: two lines fill the pipe, then in_ready must drop
        check_lat = 1'b0;
        out_ready = 1'b0;
        accepted  = 0;
        send(2);
        send(1);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 256'd0);
        chk("bp_accepted", accepted, 256'd2);
        @(posedge clk);
        #1;
        fork
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                send(3);
                send(6);
                send(8);
            end
        join
        drain();
        chk("bp_total_accepted", accepted, 256'd5);

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(4);
        send(5);
        chk("pre_rst_out_valid", out_valid, 256'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 256'd0);
        chk("midrst_out_data", out_data, 256'd0);
        chk("midrst_out_enc", out_enc, 256'd0);
        chk("midrst_out_len", out_len, 256'd0);
        sb.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        check_lat = 1'b1;
        send(7);
        drain();
        repeat (3) @(negedge clk);
        chk("post_rst_idle", out_valid, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bdi_compressor_pipe.md
Name: bdi_compressor_pipe

Overview:
- Parametrised, pipelined base-delta-immediate (BDI) cache-line compressor.
- Evaluates eight fixed compression modes in parallel (zero line, repeated word, and six base/delta combinations). Selects the smallest legal encoding and emits a packed line with its byte length.
- Sits between the line buffer and the compressed-line store. Uses valid/ready handshakes on both sides and supports full backpressure.

Parameters:
- LINE_W, 256, line width in bits; multiple of 64, legal range 128..512.
- CNT_W, 32, width of statistics counters (used only with BDI_STATS_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input line valid.
- in_ready  out  1  block can accept a line this cycle.
- in_data  in  LINE_W  uncompressed line; word 0 at LSBs.
- out_valid  out  1  compressed result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LINE_W  packed line; unused MSBs are zero.
- out_enc  out  4  encoding code (see package).
- out_len  out  $clog2(LINE_W/8)+1  packed size in bytes.

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Pipeline structure: two register stages, S1 then S2.
  - S1 registers the line, per-mode fit flags and all deltas.
  - S2 registers the selected out_data, out_enc and out_len; out_valid is the S2 valid bit.
- Latency is exactly 2 cycles from input transfer to out_valid when there is no stall. Throughput is 1 line per cycle.
- Stall rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready equals the S1-advance condition (combinational); it is 0 while rst is high.
  - While stalled, S2 outputs are held stable.
- Delta arithmetic: for base size B bytes, N = LINE_W/(8*B) words; base = word 0.
  - delta_i = word_i - base, modulo 2^(8B), two's complement, for i = 1..N-1.
  - delta_i fits D bytes iff bits [8B-1:8D-1] of delta_i are all 0 or all 1.
  - A mode is legal iff every delta_i fits.
- Modes, sizes and legality:
  - ZERO (enc 0): whole line == 0; size 0.
  - REP8 (enc 1): all 64-bit words are equal; size 8.
  - B8D1 (enc 2): size 8 + (N8-1)*1.
  - B8D2 (enc 3): size 8 + (N8-1)*2.
  - B8D4 (enc 4): size 8 + (N8-1)*4.
  - B4D1 (enc 5): size 4 + (N4-1)*1.
  - B4D2 (enc 6): size 4 + (N4-1)*2.
  - B2D1 (enc 7): size 2 + (N2-1)*1.
  - RAW (enc 15): always legal; size LINE_W/8.
- Selection:
  - Choose the legal mode with the minimum size; ties go to the lower encoding value.
  - A compressed mode is used only if its size < LINE_W/8; otherwise RAW.
- Packing:
  - Base at out_data[8B-1:0], then delta_1..delta_{N-1} low D bytes each, contiguous, ascending.
  - REP8 packs the word in bits [63:0]. ZERO drives all zeros. RAW copies in_data.
- Reset:
  - out_valid=0, out_data=0, out_enc=0, out_len=0; all stage valids cleared.
  - Assertion mid-operation drops in-flight lines silently; no partial output.
- Reserved encodings 8..14 are never produced.

Optional Feature:
- Macro BDI_STATS_EN.
- With the macro defined:
  - Adds outputs stat_lines, stat_raw and stat_saved (each CNT_W bits).
  - stat_lines counts output transfers; stat_raw counts RAW output transfers.
  - stat_saved accumulates (LINE_W/8 - out_len) per output transfer.
  - Counters saturate at all-ones and clear on rst.
- Without the macro: these ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package bdi_pkg:
  - enc_e enum (ENC_ZERO, ENC_REP8, ENC_B8D1, ENC_B8D2, ENC_B8D4, ENC_B4D1, ENC_B4D2, ENC_B2D1, ENC_RAW).
  - Size function bdi_size(enc, line_w).
  - ENC_W=4.
- Sub-module bdi_fit_check:
  - Parameters BASE_B, LINE_W.
  - Computes deltas and 1/2/4-byte fit flags for one base size.
  - Instantiated three times (B = 8, 4, 2).

Test Plan:
- LINE_W=256, in_data=0 -> 2 cycles later out_enc=0, out_len=0, out_data=0.
- Four 64-bit words all 0x1122334455667788 -> out_enc=1, out_len=8, out_data[63:0]=0x1122334455667788.
- 64-bit words {base=0x1000, 0x1005, 0x0FFE, 0x1010} (word0 first):
  - B4D1 is not legal (32-bit word 1 is 0, giving delta 0xFFFFF000), so B8D1 wins with out_len=11 and out_enc=2.
  - out_data[87:64]=0x10FE05.
- Random incompressible line -> out_enc=15, out_len=32, out_data==in_data.
- Backpressure:
  - Stream 5 lines with out_ready held low for 4 cycles -> in_ready drops after 2 accepted lines.
  - Outputs stay stable while stalled; all 5 lines emerge in order with no loss or duplication.
- Reset mid-stream:
  - Assert rst with both stages valid -> next cycle out_valid=0 and outputs zero.
  - After deassertion, the first new line appears exactly 2 cycles after its transfer.
